systolic_edge_feeder: RTL and testbench

Upstream stage of the systolic array. Accepts one N-lane vector of 8-bit operands per cycle over a valid/ready handshake and drives one edge of the MAC grid, so rows for the A edge or columns for the B edge. Lane k is skewed by k cycles so that operands meet in the correct PE. After each tile the block injects zero bubbles until the array has drained, then reports completion. The A and B edges each use one instance, and both instances are driven from the same start/valid controls.

---
 rtl/systolic_pkg.sv | 14 +
 rtl/skew_delay_line.sv | 29 ++
 rtl/systolic_edge_feeder.sv | 101 ++++++++++
 tb/tb_systolic_edge_feeder.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array edge feeders.
package systolic_pkg;

  localparam int unsigned DataWDefault = 8;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} feeder_state_t;

  // Cycles after the last operand until the far-corner PE has accumulated it:
  // empty the skew, cross the grid, one MAC register stage.
  function automatic int unsigned drain_cyc(input int unsigned n);
    return 2 * n - 1;
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth shift register used to skew one feeder lane; shifts every cycle.
module skew_delay_line
  import systolic_pkg::*;
#(
  parameter int unsigned DEPTH  = 1,
  parameter int unsigned DATA_W = DataWDefault
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_d,
  output logic [DATA_W-1:0] o_q
);

  logic [DEPTH-1:0][DATA_W-1:0] sr_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  assign o_q = sr_q[DEPTH-1];

endmodule

// File: rtl/systolic_edge_feeder.sv
// Edge feeder for the systolic MAC grid: takes a K-vector tile, skews lane k by k cycles,
// then flushes the array with zero bubbles and pulses o_done.
module systolic_edge_feeder
  import systolic_pkg::*;
#(
  parameter int unsigned N      = 4,
  parameter int unsigned DATA_W = DataWDefault,
  parameter int unsigned K      = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic                i_valid,
  input  logic [N*DATA_W-1:0] i_vec,
  output logic                o_ready,
  output logic [N*DATA_W-1:0] o_edge,
  output logic                o_busy,
  output logic                o_done
);

  localparam int unsigned DRAIN_CYC = drain_cyc(N);
  localparam int unsigned VecCntW   = $clog2(K + 1);
  localparam int unsigned DrainCntW = $clog2(DRAIN_CYC + 1);

  feeder_state_t         state_q;
  logic [VecCntW-1:0]    vec_cnt_q;
  logic [DrainCntW-1:0]  drain_cnt_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  accept;
  logic [N*DATA_W-1:0]   lane_in;

  // Ready is a pure state decode so it never combinationally depends on i_valid.
  assign o_ready = (state_q == LOAD);
  assign accept  = i_valid & o_ready;
  assign o_busy  = busy_q;
  assign o_done  = done_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      vec_cnt_q   <= '0;
      drain_cnt_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (i_start) begin
            state_q   <= LOAD;
            vec_cnt_q <= '0;
            busy_q    <= 1'b1;
          end
        end
        LOAD: begin
          if (accept) begin
            vec_cnt_q <= vec_cnt_q + 1'b1;
            if (vec_cnt_q == VecCntW'(K - 1)) begin
              state_q     <= DRAIN;
              drain_cnt_q <= DrainCntW'(DRAIN_CYC - 1);
            end
          end
        end
        DRAIN: begin
          if (drain_cnt_q == '0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            drain_cnt_q <= drain_cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Anything not accepted enters the skew as a zero bubble.
  always_comb begin
    lane_in = '0;
    if (accept) begin
      lane_in = i_vec;
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_lane
    skew_delay_line #(
      .DEPTH  (k + 1),
      .DATA_W (DATA_W)
    ) u_lane (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_d     (lane_in[k*DATA_W +: DATA_W]),
      .o_q     (o_edge[k*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_systolic_edge_feeder.sv
// Scoreboard bench: A and B feeders driven with shared controls into a behavioural 4x4 MAC grid.
module tb_systolic_edge_feeder;

  localparam int N     = 4;
  localparam int K     = 4;
  localparam int DRAIN = 2 * N - 1;

  typedef struct {
    int         due;
    logic [7:0] val;
  } edge_item_t;

  typedef struct {
    int   cyc;
    logic rdy;
    logic busy;
    logic done;
  } ctrl_t;

  logic        clk = 1'b0;
  logic        i_rst_n = 1'b1;
  logic        i_start = 1'b0;
  logic        i_valid = 1'b0;
  logic [31:0] i_vec = '0;
  logic [31:0] i_vec_b = '0;
  logic        o_ready, o_ready_b, o_busy, o_busy_b, o_done, o_done_b;
  logic [31:0] o_edge, o_edge_b;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  edge_item_t eq[8][$];
  ctrl_t      ctrl_q[$];
  int         mm_exp[$];

  // Tile-level model state
  bit m_load;
  int m_acc;
  int m_tile_end;
  int m_done_at;

  logic [7:0] pa[4][4];
  logic [7:0] pb[4][4];
  int         acc[4][4];

  systolic_edge_feeder #(.N(N), .DATA_W(8), .K(K)) u_dut (
    .i_clk   (clk),
    .i_rst_n (i_rst_n),
    .i_start (i_start),
    .i_valid (i_valid),
    .i_vec   (i_vec),
    .o_ready (o_ready),
    .o_edge  (o_edge),
    .o_busy  (o_busy),
    .o_done  (o_done)
  );

  systolic_edge_feeder #(.N(N), .DATA_W(8), .K(K)) u_dut_b (
    .i_clk   (clk),
    .i_rst_n (i_rst_n),
    .i_start (i_start),
    .i_valid (i_valid),
    .i_vec   (i_vec_b),
    .o_ready (o_ready_b),
    .o_edge  (o_edge_b),
    .o_busy  (o_busy_b),
    .o_done  (o_done_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural output-stationary MAC grid fed by the two edges.
  always @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j < 4; j++) begin
          pa[i][j]  <= '0;
          pb[i][j]  <= '0;
          acc[i][j] <= 0;
        end
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j < 4; j++) begin
          logic [7:0] a_in, b_in;
          a_in = (j == 0) ? o_edge[i*8 +: 8] : pa[i][j-1];
          b_in = (i == 0) ? o_edge_b[j*8 +: 8] : pb[i-1][j];
          pa[i][j] <= a_in;
          pb[i][j] <= b_in;
          if (!o_busy) acc[i][j] <= 0;
          else         acc[i][j] <= acc[i][j] + int'(a_in) * int'(b_in);
        end
      end
    end
  end

  // Monitor: compares every cycle against what the stimulus side queued.
  always @(negedge clk) begin
    ctrl_t      ce;
    edge_item_t it;
    logic [7:0] exp_v;
    if (!i_rst_n) begin
      chk("rst_edge_a", o_edge, 32'h0);
      chk("rst_edge_b", o_edge_b, 32'h0);
      chk("rst_ready", {31'h0, o_ready | o_ready_b}, 32'h0);
      chk("rst_busy", {31'h0, o_busy | o_busy_b}, 32'h0);
      chk("rst_done", {31'h0, o_done | o_done_b}, 32'h0);
    end else begin
      if (ctrl_q.size() == 0 || ctrl_q[0].cyc != cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL ctrl_sched: no expectation for cycle %0d", cyc);
      end else begin
        ce = ctrl_q.pop_front();
        chk("ready_a", {31'h0, o_ready}, {31'h0, ce.rdy});
        chk("busy_a", {31'h0, o_busy}, {31'h0, ce.busy});
        chk("done_a", {31'h0, o_done}, {31'h0, ce.done});
        chk("ready_b", {31'h0, o_ready_b}, {31'h0, ce.rdy});
        chk("busy_b", {31'h0, o_busy_b}, {31'h0, ce.busy});
        chk("done_b", {31'h0, o_done_b}, {31'h0, ce.done});
      end
      for (int s = 0; s < 8; s++) begin
        exp_v = 8'h0;
        while (eq[s].size() > 0 && eq[s][0].due < cyc) begin
          it = eq[s].pop_front();
          n_tests++;
          n_fail++;
          $display("FAIL edge_stale q%0d: due %0d never shown", s, it.due);
        end
        if (eq[s].size() > 0 && eq[s][0].due == cyc) begin
          it    = eq[s].pop_front();
          exp_v = it.val;
        end
        if (s < 4) chk($sformatf("edge_a_l%0d", s), {24'h0, o_edge[s*8 +: 8]}, {24'h0, exp_v});
        else       chk($sformatf("edge_b_l%0d", s - 4), {24'h0, o_edge_b[(s-4)*8 +: 8]},
                       {24'h0, exp_v});
      end
      if (o_done && mm_exp.size() >= 16) begin
        for (int i = 0; i < 4; i++) begin
          for (int j = 0; j < 4; j++) begin
            chk($sformatf("matmul_c%0d%0d", i, j), acc[i][j], mm_exp.pop_front());
          end
        end
      end
    end
  end

  task automatic model_reset();
    m_load     = 1'b0;
    m_acc      = 0;
    m_tile_end = -1000;
    m_done_at  = -1000;
  endtask

  task automatic flush();
    for (int s = 0; s < 8; s++) eq[s].delete();
    ctrl_q.delete();
    mm_exp.delete();
    model_reset();
  endtask

  // Apply the handshake rules for the current cycle and queue what follows from them.
  task automatic model_cycle(input logic st, input logic vl, input logic [31:0] va,
                             input logic [31:0] vb);
    int         c;
    bit         acc_now, idle_now;
    edge_item_t it;
    ctrl_t      ce;
    c        = cyc;
    acc_now  = m_load && vl;
    idle_now = !m_load && (c > m_tile_end);
    if (acc_now) begin
      for (int k = 0; k < 4; k++) begin
        it.due = c + k + 1;
        it.val = va[k*8 +: 8];
        eq[k].push_back(it);
        it.val = vb[k*8 +: 8];
        eq[4+k].push_back(it);
      end
      m_acc++;
      if (m_acc == K) begin
        m_load     = 1'b0;
        m_tile_end = c + DRAIN;
        m_done_at  = c + DRAIN + 1;
      end
    end
    if (idle_now && st) begin
      m_load = 1'b1;
      m_acc  = 0;
    end
    ce.cyc  = c + 1;
    ce.rdy  = m_load;
    ce.busy = m_load || (c + 1 <= m_tile_end);
    ce.done = (c + 1 == m_done_at);
    ctrl_q.push_back(ce);
  endtask

  task automatic step(input logic st, input logic vl, input logic [31:0] va,
                      input logic [31:0] vb);
    @(negedge clk);
    #1;
    i_start = st;
    i_valid = vl;
    i_vec   = va;
    i_vec_b = vb;
    model_cycle(st, vl, va, vb);
  endtask

  task automatic apply_reset(input int ncyc, input bit check_now);
    @(negedge clk);
    #1;
    i_rst_n = 1'b0;
    #1;
    if (check_now) begin
      chk("midrst_edge", o_edge | o_edge_b, 32'h0);
      chk("midrst_ready", {31'h0, o_ready}, 32'h0);
      chk("midrst_busy", {31'h0, o_busy}, 32'h0);
    end
    flush();
    repeat (ncyc) begin
      @(negedge clk);
      #1;
      i_start = 1'b1;
      i_valid = 1'b1;
      i_vec   = $urandom;
      i_vec_b = $urandom;
    end
    @(negedge clk);
    #1;
    i_rst_n = 1'b1;
    i_start = 1'b0;
    i_valid = 1'b0;
    model_cycle(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    logic [7:0]  ma[4][4];
    logic [7:0]  mb[4][4];
    logic [31:0] va[4];
    logic [31:0] vb[4];
    int          sum;

    #1 i_rst_n = 1'b0;
    model_reset();
    apply_reset(3, 1'b0);

    // Skew: known ramp vectors
    step(1'b1, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b1, 32'h04030201, 32'h44332211);
    step(1'b0, 1'b1, 32'h08070605, 32'h88776655);
    step(1'b0, 1'b1, 32'h0c0b0a09, 32'hccbbaa99);
    step(1'b0, 1'b1, 32'h100f0e0d, 32'h00ffeedd);
    repeat (10) step(1'b0, 1'b0, 32'h0, 32'h0);

    // Bubble + matmul through the MAC grid
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        ma[i][j] = 8'($urandom);
        mb[i][j] = 8'($urandom);
      end
    end
    for (int t = 0; t < 4; t++) begin
      for (int l = 0; l < 4; l++) begin
        va[t][l*8 +: 8] = ma[l][t];
        vb[t][l*8 +: 8] = mb[t][l];
      end
    end
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        sum = 0;
        for (int t = 0; t < 4; t++) sum += int'(ma[i][t]) * int'(mb[t][j]);
        mm_exp.push_back(sum);
      end
    end
    step(1'b1, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b1, va[0], vb[0]);
    step(1'b0, 1'b1, va[1], vb[1]);
    step(1'b0, 1'b0, $urandom, $urandom);
    step(1'b0, 1'b0, $urandom, $urandom);
    step(1'b0, 1'b1, va[2], vb[2]);
    step(1'b0, 1'b1, va[3], vb[3]);
    repeat (12) step(1'b0, 1'b0, 32'h0, 32'h0);

    // Ignored controls: start in LOAD/DRAIN, 0xFF data offered during DRAIN
    step(1'b1, 1'b1, 32'hffffffff, 32'hffffffff);
    step(1'b1, 1'b1, $urandom, $urandom);
    step(1'b1, 1'b0, $urandom, $urandom);
    step(1'b1, 1'b1, $urandom, $urandom);
    step(1'b0, 1'b1, $urandom, $urandom);
    step(1'b1, 1'b1, $urandom, $urandom);
    for (int i = 0; i < DRAIN; i++) step(i[0], 1'b1, 32'hffffffff, 32'hffffffff);
    step(1'b0, 1'b1, 32'hffffffff, 32'hffffffff);
    repeat (3) step(1'b0, 1'b0, 32'h0, 32'h0);

    // Back-to-back tiles with start held high
    repeat (30) step(1'b1, 1'b1, $urandom, $urandom);
    repeat (14) step(1'b0, 1'b0, 32'h0, 32'h0);

    // Mid-tile reset after two accepts
    step(1'b1, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b1, $urandom, $urandom);
    step(1'b0, 1'b1, $urandom, $urandom);
    apply_reset(2, 1'b1);
    repeat (14) step(1'b0, 1'b0, 32'h0, 32'h0);

    // Random traffic
    repeat (250) step(($urandom % 5) == 0, ($urandom % 10) < 7, $urandom, $urandom);
    repeat (12) step(1'b0, 1'b0, 32'h0, 32'h0);

    chk("matmul_pending", mm_exp.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
